// File: rtl/fp32_pkg.sv
// Shared binary32 constants, FSM state type and operand classification
// for the floating-point arithmetic unit.
package fp32_pkg;

    localparam int BIAS  = 127;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        DIVIDE,
        ROUND,
        DONE
    } div_state_t;

    typedef struct packed {
        logic is_zero;
        logic is_inf;
        logic is_nan;
    } fp_class_t;

    // Exponent field 0 counts as zero regardless of fraction, so subnormals flush.
    function automatic fp_class_t fp_classify(input logic [31:0] x);
        fp_class_t c;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] f;
        e = x[MAN_W +: EXP_W];
        f = x[MAN_W-1:0];
        c.is_zero = (e == '0);
        c.is_inf  = (e == '1) && (f == '0);
        c.is_nan  = (e == '1) && (f != '0);
        return c;
    endfunction

endpackage

// File: rtl/fp32_seq_divider_if.sv
// Operand/result handshake bundle for the sequential divider.
interface fp32_seq_divider_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        div_by_zero;
    logic        invalid;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out, div_by_zero, invalid
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out, div_by_zero, invalid
    );
endinterface

// File: rtl/fp32_round_pack.sv
// Round-to-nearest-even of a 26-bit quotient (1.23 + guard + round) plus
// sticky, with exponent overflow/underflow handling and binary32 packing.
module fp32_round_pack
    import fp32_pkg::*;
(
    input  logic              sign,
    input  logic signed [9:0] exp_in,
    input  logic [25:0]       quo,
    input  logic              sticky,
    output logic [31:0]       result
);

    logic              guard;
    logic              round_sticky;
    logic              round_up;
    logic              carry;
    logic [MAN_W-1:0]  frac;
    logic signed [9:0] exp_adj;

    always_comb begin
        guard        = quo[1];
        round_sticky = quo[0] | sticky;
        round_up     = guard & (round_sticky | quo[2]);
        // An all-ones mantissa rounding up wraps the fraction to 0 and bumps the exponent.
        carry        = round_up & (&quo[25:2]);
        frac         = quo[24:2] + {{(MAN_W-1){1'b0}}, round_up};
        exp_adj      = carry ? (exp_in + 10'sd1) : exp_in;

        if (exp_adj >= 10'sd255) begin
            result = {sign, POS_INF[30:0]};
        end else if (exp_adj <= 10'sd0) begin
            result = {sign, 31'b0};
        end else begin
            result = {sign, exp_adj[EXP_W-1:0], frac};
        end
    end

endmodule

// File: rtl/fp32_seq_divider.sv
// Sequential binary32 divider: restoring radix-2 mantissa division, one
// quotient bit per cycle, FTZ, RNE rounding, canonical NaN.
module fp32_seq_divider
    import fp32_pkg::*;
#(
    parameter int ITER = 26
) (
    input  logic              clk,
    input  logic              rst_n,
    fp32_seq_divider_if.slave bus
);

    div_state_t        state_reg;
    logic [31:0]       a_reg;
    logic [31:0]       b_reg;
    logic              sign_reg;
    logic signed [9:0] exp_reg;
    logic [23:0]       mb_reg;
    logic [24:0]       rem_reg;
    logic [25:0]       quo_reg;
    logic [4:0]        cnt_reg;
    logic              in_ready_reg;
    logic              out_valid_reg;
    logic [31:0]       out_reg;
    logic              dbz_reg;
    logic              invalid_reg;

    assign bus.in_ready    = in_ready_reg;
    assign bus.out_valid   = out_valid_reg;
    assign bus.out         = out_reg;
    assign bus.div_by_zero = dbz_reg;
    assign bus.invalid     = invalid_reg;

    // Unpack and special-case decode of the captured operands.
    fp_class_t   class_a;
    fp_class_t   class_b;
    logic        sign_ab;
    logic [23:0] ma;
    logic [23:0] mb;
    logic        adj;
    logic [24:0] rem_init;
    logic [9:0]  exp_calc;
    logic        special_hit;
    logic [31:0] special_res;
    logic        special_dbz;
    logic        special_inv;

    always_comb begin
        class_a  = fp_classify(a_reg);
        class_b  = fp_classify(b_reg);
        sign_ab  = a_reg[31] ^ b_reg[31];
        ma       = {1'b1, a_reg[MAN_W-1:0]};
        mb       = {1'b1, b_reg[MAN_W-1:0]};
        // Pre-normalise so the quotient lands in [1,2) and bit 25 is the integer bit.
        adj      = (ma < mb);
        rem_init = adj ? {ma, 1'b0} : {1'b0, ma};
        exp_calc = {2'b00, a_reg[30:23]} - {2'b00, b_reg[30:23]}
                 + 10'(BIAS) - {9'b0, adj};

        special_hit = 1'b1;
        special_res = '0;
        special_dbz = 1'b0;
        special_inv = 1'b0;
        if (class_a.is_nan || class_b.is_nan ||
            (class_a.is_zero && class_b.is_zero) ||
            (class_a.is_inf && class_b.is_inf)) begin
            special_res = QNAN;
            special_inv = 1'b1;
        end else if (class_a.is_inf) begin
            special_res = {sign_ab, POS_INF[30:0]};
        end else if (class_b.is_zero) begin
            special_res = {sign_ab, POS_INF[30:0]};
            special_dbz = !class_a.is_zero;
        end else if (class_a.is_zero || class_b.is_inf) begin
            special_res = {sign_ab, 31'b0};
        end else begin
            special_hit = 1'b0;
        end
    end

    // One restoring step: subtract when the remainder covers the divisor.
    logic        rem_ge;
    logic [24:0] rem_sub;
    logic [24:0] rem_next;

    always_comb begin
        rem_ge   = (rem_reg >= {1'b0, mb_reg});
        rem_sub  = rem_ge ? (rem_reg - {1'b0, mb_reg}) : rem_reg;
        rem_next = {rem_sub[23:0], 1'b0};
    end

    logic [31:0] rounded;

    fp32_round_pack u_round_pack (
        .sign   (sign_reg),
        .exp_in (exp_reg),
        .quo    (quo_reg),
        .sticky (|rem_reg),
        .result (rounded)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            sign_reg      <= 1'b0;
            exp_reg       <= '0;
            mb_reg        <= '0;
            rem_reg       <= '0;
            quo_reg       <= '0;
            cnt_reg       <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            out_reg       <= '0;
            dbz_reg       <= 1'b0;
            invalid_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg        <= bus.in_a;
                        b_reg        <= bus.in_b;
                        in_ready_reg <= 1'b0;
                        state_reg    <= UNPACK;
                    end
                end
                UNPACK: begin
                    if (special_hit) begin
                        out_reg       <= special_res;
                        dbz_reg       <= special_dbz;
                        invalid_reg   <= special_inv;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        sign_reg  <= sign_ab;
                        exp_reg   <= $signed(exp_calc);
                        mb_reg    <= mb;
                        rem_reg   <= rem_init;
                        quo_reg   <= '0;
                        cnt_reg   <= '0;
                        state_reg <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    rem_reg <= rem_next;
                    quo_reg <= {quo_reg[24:0], rem_ge};
                    cnt_reg <= cnt_reg + 5'd1;
                    if (cnt_reg == 5'(ITER - 1)) begin
                        state_reg <= ROUND;
                    end
                end
                ROUND: begin
                    out_reg       <= rounded;
                    dbz_reg       <= 1'b0;
                    invalid_reg   <= 1'b0;
                    out_valid_reg <= 1'b1;
                    state_reg     <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_seq_divider.sv
// Directed-vector bench for fp32_seq_divider: values, latency, flags,
// backpressure and mid-operation reset.
module tb_fp32_seq_divider;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp32_seq_divider_if bus ();

    fp32_seq_divider #(.ITER(26)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    localparam int NN = 8;
    localparam logic [31:0] NA [NN] = '{32'h40C00000, 32'h3F800000, 32'hBF800000, 32'h41200000,
                                        32'h40000000, 32'h3F800000, 32'h7F7FFFFF, 32'h00800000};
    localparam logic [31:0] NB [NN] = '{32'h40000000, 32'h40400000, 32'h40400000, 32'h40800000,
                                        32'h40400000, 32'h3F800000, 32'h3F000000, 32'h40000000};
    localparam logic [31:0] NQ [NN] = '{32'h40400000, 32'h3EAAAAAB, 32'hBEAAAAAB, 32'h40200000,
                                        32'h3F2AAAAB, 32'h3F800000, 32'h7F800000, 32'h00000000};

    localparam int NS = 10;
    localparam logic [31:0] SA [NS] = '{32'h3F800000, 32'h00000000, 32'hC0000000, 32'h7F800000,
                                        32'h7FC00001, 32'h7F800000, 32'h3F800000, 32'h80000000,
                                        32'h7F800000, 32'h00400000};
    localparam logic [31:0] SB [NS] = '{32'h00000000, 32'h00000000, 32'h00000000, 32'h7F800000,
                                        32'h3F800000, 32'hBF800000, 32'h7F800000, 32'h3F800000,
                                        32'h00000000, 32'h3F800000};
    localparam logic [31:0] SQ [NS] = '{32'h7F800000, 32'h7FC00000, 32'hFF800000, 32'h7FC00000,
                                        32'h7FC00000, 32'hFF800000, 32'h00000000, 32'h80000000,
                                        32'h7F800000, 32'h00000000};
    localparam logic [1:0]  SF [NS] = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b01,
                                        2'b00, 2'b00, 2'b00, 2'b00, 2'b00};

    // Presents one operand pair (entry: #1 after an edge, DUT idle) and waits,
    // bounded, for out_valid. lat = cycles from accept edge, -1 on timeout.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic [1:0] flags, output int lat);
        bus.in_a = a;
        bus.in_b = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (bus.out_valid !== 1'b1) lat = -1;
        r = bus.out;
        flags = {bus.div_by_zero, bus.invalid};
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if ({bus.in_ready, bus.out_valid, bus.div_by_zero, bus.invalid} !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset_ctrl got rdy/vld/dbz/inv=%b want 1000",
                     {bus.in_ready, bus.out_valid, bus.div_by_zero, bus.invalid});
        end
        vectors++;
        if (bus.out !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_out got %h want 00000000", bus.out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_normal();
        logic [31:0] r;
        logic [1:0] f;
        int lat;
        for (int i = 0; i < NN; i++) begin
            do_op(NA[i], NB[i], r, f, lat);
            $display("normal %h / %h -> %h flags=%b lat=%0d", NA[i], NB[i], r, f, lat);
            vectors++;
            if (r !== NQ[i]) begin
                miscompares++;
                $display("FAIL normal_val[%0d] got %h want %h", i, r, NQ[i]);
            end
            vectors++;
            if (lat !== 28) begin
                miscompares++;
                $display("FAIL normal_lat[%0d] got %0d want 28", i, lat);
            end
            vectors++;
            if (f !== 2'b00) begin
                miscompares++;
                $display("FAIL normal_flags[%0d] got %b want 00", i, f);
            end
            release_out();
        end
    endtask

    task automatic test_special();
        logic [31:0] r;
        logic [1:0] f;
        int lat;
        for (int i = 0; i < NS; i++) begin
            do_op(SA[i], SB[i], r, f, lat);
            $display("special %h / %h -> %h flags=%b lat=%0d", SA[i], SB[i], r, f, lat);
            vectors++;
            if (r !== SQ[i]) begin
                miscompares++;
                $display("FAIL special_val[%0d] got %h want %h", i, r, SQ[i]);
            end
            vectors++;
            if (f !== SF[i]) begin
                miscompares++;
                $display("FAIL special_flags[%0d] got %b want %b", i, f, SF[i]);
            end
            vectors++;
            if (lat !== 1) begin
                miscompares++;
                $display("FAIL special_lat[%0d] got %0d want 1", i, lat);
            end
            release_out();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] r;
        logic [1:0] f;
        int lat;
        do_op(32'h40C00000, 32'h40000000, r, f, lat);
        $display("bp %h / %h -> %h lat=%0d", 32'h40C00000, 32'h40000000, r, lat);
        bus.in_a = 32'h3F800000;
        bus.in_b = 32'h40400000;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            vectors++;
            if ({bus.out_valid, bus.in_ready, bus.out} !== {2'b10, 32'h40400000}) begin
                miscompares++;
                $display("FAIL bp_hold[%0d] got vld=%b rdy=%b out=%h want vld=1 rdy=0 out=40400000",
                         c, bus.out_valid, bus.in_ready, bus.out);
            end
        end
        bus.in_valid = 1'b0;
        release_out();
        vectors++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL bp_release got rdy=%b vld=%b want rdy=1 vld=0", bus.in_ready, bus.out_valid);
        end
        do_op(32'h40000000, 32'h40000000, r, f, lat);
        $display("bp_next %h / %h -> %h lat=%0d", 32'h40000000, 32'h40000000, r, lat);
        vectors++;
        if (r !== 32'h3F800000 || lat !== 28) begin
            miscompares++;
            $display("FAIL bp_next got %h lat=%0d want 3f800000 lat=28", r, lat);
        end
        release_out();
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        logic [1:0] f;
        int lat;
        for (int i = 0; i < 3; i++) begin
            do_op(NA[i], NB[i], r, f, lat);
            $display("b2b %h / %h -> %h lat=%0d", NA[i], NB[i], r, lat);
            vectors++;
            if (r !== NQ[i] || lat !== 28) begin
                miscompares++;
                $display("FAIL b2b[%0d] got %h lat=%0d want %h lat=28", i, r, lat, NQ[i]);
            end
            release_out();
            vectors++;
            if (bus.in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_ready[%0d] got %b want 1", i, bus.in_ready);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        logic [1:0] f;
        int lat;
        int seen;
        bus.in_a = 32'h40C00000;
        bus.in_b = 32'h40000000;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (11) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.out_valid, bus.in_ready, bus.out} !== {2'b01, 32'h0}) begin
            miscompares++;
            $display("FAIL mid_reset got vld=%b rdy=%b out=%h want vld=0 rdy=1 out=00000000",
                     bus.out_valid, bus.in_ready, bus.out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b0) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("FAIL mid_reset_quiet got %0d valid cycles want 0", seen);
        end
        do_op(32'h40C00000, 32'h40000000, r, f, lat);
        $display("post_reset %h / %h -> %h lat=%0d", 32'h40C00000, 32'h40000000, r, lat);
        vectors++;
        if (r !== 32'h40400000 || lat !== 28) begin
            miscompares++;
            $display("FAIL post_reset got %h lat=%0d want 40400000 lat=28", r, lat);
        end
        release_out();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_normal();
        test_special();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
